uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver core.
- Captures each byte the receiver completes, holds up to DEPTH bytes, and presents them to the register interface's RX_DATA read path one at a time.
- Reports occupancy, overrun, level threshold and (optionally) character timeout, so software can drain bursts without losing bytes.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, 4, log2(DEPTH); pointer width.
- TIMEOUT_TICKS, 40, baud_tick count of idle before timeout_irq; used only with the optional feature.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_byte  input  8  byte from receiver; valid only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe: receiver completed a byte.
- baud_tick  input  1  baud-rate strobe from baud generator (timeout feature only).
- pop  input  1  single-cycle read request from register block (RX_DATA read).
- flush  input  1  synchronous clear of contents and flags.
- ovr_clr  input  1  clears sticky overrun flag.
- thresh  input  AW+1  level-interrupt threshold; 0 disables.
- rd_data  output  8  registered head byte returned for a pop.
- count  output  AW+1  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overrun  output  1  sticky: a byte was dropped.
- level_irq  output  1  thresh!=0 and count>=thresh.
- timeout_irq  output  1  character timeout (0 without the feature).

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, rd_data=0x00, overrun=0, timeout_irq=0.
- Resulting outputs: empty=1, full=0, level_irq=0.
- Push: rx_valid=1 and (not full, or pop in the same cycle) -> mem[wr_ptr]<=rx_byte; wr_ptr wraps modulo DEPTH.
- Pop: pop=1 and not empty -> rd_data<=mem[rd_ptr] on that edge (1-cycle latency, matches the registered read path); rd_ptr wraps.
- Pop on empty: rd_data<=0x00; pointers and count unchanged; no error flag.
- Push+pop same cycle:
  - Not empty: both occur, count unchanged, including when full (no overrun).
  - Empty: the push occurs, pop returns 0x00, count becomes 1.
- Overrun: rx_valid=1 while full without a pop -> byte dropped, contents unchanged, overrun<=1.
- Overrun stays set until ovr_clr, flush or reset. If ovr_clr and a new overrun event occur together, set wins.
- Flush:
  - Pointers, count and rd_data are zeroed; overrun and timeout_irq are cleared.
  - flush has priority over push/pop in the same cycle; the concurrent byte is discarded.
- count is maintained as a separate register: +1 on push-only, -1 on pop-only. It must never exceed DEPTH or go below 0.
- empty, full and level_irq are combinational from count and thresh. thresh>DEPTH means level_irq is never asserted.

Optional Feature:
- Macro UART_RX_FIFO_TIMEOUT_EN.
- With the macro defined:
  - An idle counter (width sufficient for TIMEOUT_TICKS) is cleared on any push, pop, flush or reset.
  - It increments on baud_tick only while count!=0, and saturates at TIMEOUT_TICKS.
  - When it reaches TIMEOUT_TICKS, timeout_irq<=1.
  - timeout_irq clears on the next pop, flush or reset.
- With the macro undefined: no counter; timeout_irq tied 0; baud_tick unused.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - Register address constants: BAUD_DATA=0, ENABLE=1, TX_DATA=2, RX_DATA=3.
  - Default FIFO depth.
  - A status bit-position constant for each of empty, full, overrun, level_irq and timeout_irq, so the register block can pack a status word.
- One natural sub-module, uart_fifo_mem:
  - DEPTH x 8 storage, one write port and one synchronous read port, with no reset on the array.
  - Reusable later for a TX FIFO.
- Pointer, count and flag logic stays in uart_rx_fifo.

Test Plan:
- Reset, then pop with no data -> rd_data=0x00, empty=1, count=0, pointers unchanged.
- Push 0x11,0x22,0x33, then pop three times -> rd_data 0x11,0x22,0x33, each one cycle after its pop; count 3->0; empty=1 at end.
- Push 16 bytes 0x00..0x0F, then push 0xAA -> full=1, overrun=1, count=16.
  - Pop all 16 -> data 0x00..0x0F; 0xAA is never returned.
  - ovr_clr -> overrun=0.
- Fill to 16, then push 0x55 and pop in the same cycle -> no overrun, count=16. Drain -> last byte 0x55; verifies wrap-around.
- thresh=4: push 3 bytes -> level_irq=0; 4th push -> level_irq=1; one pop -> 0. Flush -> count=0, overrun=0, rd_data=0x00.
- With UART_RX_FIFO_TIMEOUT_EN, TIMEOUT_TICKS=40:
  - Push 1 byte, then 39 baud_ticks -> timeout_irq=0; 40th tick -> timeout_irq=1.
  - Pop -> timeout_irq=0.
  - Assert rst mid-count -> all flags 0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART constants (data width, register map, status bits)
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    BAUD_DATA = 2'd0,
    ENABLE    = 2'd1,
    TX_DATA   = 2'd2,
    RX_DATA   = 2'd3
  } uart_addr_e;

  localparam int STAT_EMPTY_BIT   = 0;
  localparam int STAT_FULL_BIT    = 1;
  localparam int STAT_OVERRUN_BIT = 2;
  localparam int STAT_LEVEL_BIT   = 3;
  localparam int STAT_TIMEOUT_BIT = 4;
  localparam int STAT_W           = 5;

  function automatic logic [STAT_W-1:0] pack_status(
    input logic empty,
    input logic full,
    input logic overrun,
    input logic level_irq,
    input logic timeout_irq
  );
    logic [STAT_W-1:0] s;
    s                   = '0;
    s[STAT_EMPTY_BIT]   = empty;
    s[STAT_FULL_BIT]    = full;
    s[STAT_OVERRUN_BIT] = overrun;
    s[STAT_LEVEL_BIT]   = level_irq;
    s[STAT_TIMEOUT_BIT] = timeout_irq;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// uart_fifo_mem : DEPTH x DW storage, one write port, one synchronous read port
// Revision      : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = UART_DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Read returns the pre-write contents when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : UART receive byte FIFO with overrun, level and timeout flags
// Optional macro UART_RX_FIFO_TIMEOUT_EN enables the character timeout.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH         = UART_RX_FIFO_DEPTH,
  parameter int AW            = $clog2(DEPTH),
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_byte,
  input  logic                   rx_valid,
  input  logic                   baud_tick,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   ovr_clr,
  input  logic [AW:0]            thresh,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun,
  output logic                   level_irq,
  output logic                   timeout_irq
);

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   rd_zero_q, rd_zero_d;
  logic                   overrun_q, overrun_d;
  logic                   do_push, do_pop, drop;
  logic [UART_DATA_W-1:0] mem_rdata;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign level_irq = (thresh != '0) && (count_q >= thresh);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a byte.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = rx_valid && (!full || pop) && !flush;
  assign drop    = rx_valid && full && !pop && !flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_zero_d = rd_zero_q;
    overrun_d = overrun_q;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_zero_d = 1'b1;
      overrun_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // Pop on empty returns zero instead of stale storage.
      if (pop) rd_zero_d = empty;
      if (drop)         overrun_d = 1'b1;
      else if (ovr_clr) overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_zero_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_zero_q <= rd_zero_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (UART_DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr_q),
    .wdata (rx_byte),
    .re    (do_pop),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign rd_data = rd_zero_q ? '0 : mem_rdata;
  assign count   = count_q;
  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (flush || pop || do_push) begin
      idle_d = '0;
    end else if (baud_tick && !empty && (idle_q != IW'(TIMEOUT_TICKS))) begin
      idle_d = idle_q + 1'b1;
    end
    if (flush || pop)                       timeout_d = 1'b0;
    else if (idle_d == IW'(TIMEOUT_TICKS)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_irq = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = baud_tick ^ (TIMEOUT_TICKS == 0);
  assign timeout_irq    = 1'b0;
`endif

endmodule

`default_nettype wire
